// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    RID_0 = 1'b0,
    RID_1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between the two requesters.
// DMEM_ARB_RR_EN defined: round-robin on ties; undefined: R0 fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic    i_req0,
  input  logic    i_req1,
  input  req_id_t i_last,
  output req_id_t o_win
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    o_win = RID_0;
    if (i_req0 && i_req1) o_win = (i_last == RID_0) ? RID_1 : RID_0;
    else if (i_req1)      o_win = RID_1;
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last;
  assign o_win = (i_req0 || !i_req1) ? RID_0 : RID_1;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// DMEM_ARB_RR_EN selects round-robin tie breaking (default: R0 fixed priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WORDS = DMEM_WORDS
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        R0_req,
  input  logic        R0_write,
  input  logic [31:0] R0_address,
  input  logic [31:0] R0_wdata,
  input  logic        R1_req,
  input  logic        R1_write,
  input  logic [31:0] R1_address,
  input  logic [31:0] R1_wdata,
  output logic        R0_ack,
  output logic [31:0] R0_rdata,
  output logic        R0_err,
  output logic        R1_ack,
  output logic [31:0] R1_rdata,
  output logic        R1_err,
  output logic        DARB_busy,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  arb_state_t  r_state, w_next;
  req_id_t     r_gnt, w_win, w_last;
  logic        r_wr, r_oob;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_any, w_grant, w_wr;
  logic [31:0] w_addr, w_wdata;

  assign w_any   = R0_req | R1_req;
  assign w_grant = (r_state == ST_IDLE) && w_any;
  assign w_wr    = (w_win == RID_0) ? R0_write   : R1_write;
  assign w_addr  = (w_win == RID_0) ? R0_address : R1_address;
  assign w_wdata = (w_win == RID_0) ? R0_wdata   : R1_wdata;

`ifdef DMEM_ARB_RR_EN
  req_id_t r_last;
  // Reset to "last granted R1" so R0 wins the first tie.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset)    r_last <= RID_1;
    else if (w_grant) r_last <= w_win;
  end
  assign w_last = r_last;
`else
  assign w_last = RID_1;
`endif

  dmem_arb_pick u_pick (
    .i_req0 (R0_req),
    .i_req1 (R1_req),
    .i_last (w_last),
    .o_win  (w_win)
  );

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Payload is captured only at the grant edge.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      r_gnt   <= RID_0;
      r_wr    <= 1'b0;
      r_oob   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_gnt   <= w_win;
        r_wr    <= w_wr;
        r_oob   <= (w_addr >= 32'(WORDS));
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
      if (r_state == ST_ACCESS)
        r_rdata <= (!r_oob && !r_wr) ? DMEM_data_out : '0;
    end
  end

  always_comb begin
    DMEM_address   = '0;
    DMEM_data_in   = '0;
    DMEM_mem_write = 1'b0;
    DMEM_mem_read  = 1'b0;
    if (r_state == ST_ACCESS && !r_oob) begin
      DMEM_address = r_addr;
      if (r_wr) begin
        DMEM_data_in   = r_wdata;
        DMEM_mem_write = ~SYS_reset;
      end else begin
        DMEM_mem_read  = 1'b1;
      end
    end
  end

  assign DARB_busy = (r_state != ST_IDLE);
  assign R0_ack    = (r_state == ST_RESP) && (r_gnt == RID_0);
  assign R1_ack    = (r_state == ST_RESP) && (r_gnt == RID_1);
  assign R0_err    = R0_ack & r_oob;
  assign R1_err    = R1_ack & r_oob;
  assign R0_rdata  = R0_ack ? r_rdata : '0;
  assign R1_rdata  = R1_ack ? r_rdata : '0;

endmodule
